// File: rtl/servo_pkg.sv
// Shared definitions for the servo frame scheduler: the scheduler FSM
// encoding, the default duty limits, and the duty clamp that the EMG
// classifier also uses.
package servo_pkg;

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        ARM    = 2'd1,
        RUN    = 2'd2,
        HOLD   = 2'd3
    } servo_state_t;

    localparam int SERVO_DUTY_MIN = 50000;   // 1.0 ms at 50 MHz
    localparam int SERVO_DUTY_MAX = 100000;  // 2.0 ms at 50 MHz
    localparam int SERVO_DUTY_CTR = 75000;   // 1.5 ms neutral

    // Saturate a requested duty into [lo, hi]; all operands unsigned.
    function automatic logic [31:0] clamp_duty(input logic [31:0] d,
                                               input logic [31:0] lo,
                                               input logic [31:0] hi);
        logic [31:0] r;
        r = d;
        if (d < lo) r = lo;
        if (d > hi) r = hi;
        return r;
    endfunction

endpackage

// File: rtl/servo_frame_scheduler_slew.sv
// One channel of duty slew limiting: on each enable the presented duty moves
// toward the target by at most STEP. The difference is formed one bit wider
// than the duty so the magnitude test never wraps.
module servo_slew_step #(
    parameter int DBIT    = 20,
    parameter int STEP    = 2500,
    parameter int RST_VAL = 75000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [DBIT-1:0] target,
    output logic [DBIT-1:0] current
);

    localparam logic [DBIT:0] STEP_W = (DBIT+1)'(STEP);

    logic [DBIT:0] diff_up;
    logic [DBIT:0] diff_dn;

    assign diff_up = {1'b0, target} - {1'b0, current};
    assign diff_dn = {1'b0, current} - {1'b0, target};

    // Step current toward target, landing exactly on it once within STEP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            current <= DBIT'(RST_VAL);
        end else if (en) begin
            if (target >= current)
                current <= (diff_up > STEP_W) ? current + STEP_W[DBIT-1:0] : target;
            else
                current <= (diff_dn > STEP_W) ? current - STEP_W[DBIT-1:0] : target;
        end
    end

endmodule

// File: rtl/servo_frame_scheduler.sv
// Servo frame scheduler: owns the 50 Hz frame timer, arms the pwm generators
// once the supply has settled, emits one start pulse per channel per frame
// and slew-limits the duty presented to each generator.
// Optional build macro SERVO_STAGGER_EN: channel k starts at counter
// 1 + k*STAGGER_CYC instead of all channels starting at counter 1.
module servo_frame_scheduler
    import servo_pkg::*;
#(
    parameter int NCH           = 5,
    parameter int DBIT          = 20,
    parameter int PERIOD        = 1000000,
    parameter int GUARD         = 16,
    parameter int SETTLE_FRAMES = 4,
    parameter int DUTY_MIN      = SERVO_DUTY_MIN,
    parameter int DUTY_MAX      = SERVO_DUTY_MAX,
    parameter int DUTY_CTR      = SERVO_DUTY_CTR,
    parameter int SLEW_STEP     = 2500,
    parameter int STAGGER_CYC   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_ch,
    input  logic [DBIT-1:0]   cmd_duty,
    output logic              big_tick,
    output logic [NCH-1:0]    pwm_en,
    output logic [NCH*DBIT-1:0] duty_out,
    output logic              frame_tick,
    output logic              cmd_err,
    output servo_state_t      state_dbg
);

    localparam int FRAME = PERIOD + GUARD;
    localparam int CW    = $clog2(FRAME);
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);
    localparam int SW    = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_FRAMES - 1);

    servo_state_t    state;
    logic [CW-1:0]   cnt;
    logic [SW-1:0]   settle_cnt;
    logic            active;
    logic            at_zero;
    logic            fire_now;
    logic            slew_en;
    logic            wr_fire;
    logic            ch_bad;
    logic [DBIT-1:0] cmd_clamped;
    logic [DBIT-1:0] tgt [NCH];
    logic [DBIT-1:0] cur [NCH];

    assign active    = (state == RUN) || (state == HOLD);
    assign at_zero   = (cnt == '0);
    assign fire_now  = active && run && at_zero;
    // Update lands on the edge into counter 0, one cycle ahead of the start pulse.
    assign slew_en   = active && (cnt == LAST);
    assign state_dbg = state;

    // Target-write handshake: a write completes on a cycle where cmd_valid and
    // cmd_ready are both high; cmd_valid may be held indefinitely while
    // cmd_ready is low (settling or the duty-update cycle) and nothing is lost.
    assign cmd_ready   = (state != SETTLE) && !at_zero;
    assign wr_fire     = cmd_valid && cmd_ready;
    assign ch_bad      = (32'(cmd_ch) >= 32'(NCH));
    assign cmd_clamped = DBIT'(clamp_duty(32'(cmd_duty), 32'(DUTY_MIN), 32'(DUTY_MAX)));

    // Free-running frame counter; frame_tick is high while the counter is 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= (cnt == LAST) ? '0 : cnt + 1'b1;
            frame_tick <= (cnt == LAST);
        end
    end

    // Sequencer: settle for a number of frames, arm once, then run/hold per frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            big_tick   <= 1'b0;
        end else begin
            big_tick <= 1'b0;
            case (state)
                SETTLE: begin
                    if (frame_tick) begin
                        if (settle_cnt == SETTLE_LAST) begin
                            state    <= ARM;
                            big_tick <= 1'b1;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                end
                ARM:     state <= run ? RUN : HOLD;
                RUN:     if (at_zero && !run) state <= HOLD;
                HOLD:    if (at_zero && run) state <= RUN;
                default: state <= SETTLE;
            endcase
        end
    end

    // Bad-channel writes are dropped and reported one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cmd_err <= 1'b0;
        else        cmd_err <= wr_fire && ch_bad;
    end

    // Per-channel target store; the last accepted write to a channel wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NCH; k++) tgt[k] <= DBIT'(DUTY_CTR);
        end else begin
            for (int k = 0; k < NCH; k++)
                if (wr_fire && (cmd_ch == 3'(k))) tgt[k] <= cmd_clamped;
        end
    end

`ifdef SERVO_STAGGER_EN
    logic frame_on;

    // Staggered starts: channel 0 fires with the frame decision, the rest
    // follow at fixed offsets while the frame is marked as running.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_en   <= '0;
            frame_on <= 1'b0;
        end else begin
            if (at_zero) frame_on <= fire_now;
            for (int k = 0; k < NCH; k++) begin
                if (k == 0) pwm_en[k] <= fire_now;
                else        pwm_en[k] <= frame_on && (cnt == CW'(k * STAGGER_CYC));
            end
        end
    end
`else
    // All channels start together at counter 1 of a running frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pwm_en <= '0;
        else        pwm_en <= {NCH{fire_now}};
    end
`endif

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_ch
            servo_slew_step #(
                .DBIT    (DBIT),
                .STEP    (SLEW_STEP),
                .RST_VAL (DUTY_CTR)
            ) u_slew (
                .clk     (clk),
                .reset   (reset),
                .en      (slew_en),
                .target  (tgt[g]),
                .current (cur[g])
            );
            assign duty_out[g*DBIT +: DBIT] = cur[g];
        end
    endgenerate

endmodule

// File: tb/tb_servo_frame_scheduler.sv
// Bench for servo_frame_scheduler with a short frame. The reference model
// tracks time as "edges since reset release" and derives every output from
// frame number and position within the frame.
module tb_servo_frame_scheduler;

    localparam int NCH  = 5;
    localparam int DBIT = 20;
    localparam int PER  = 200;
    localparam int GRD  = 16;
    localparam int SF   = 2;
    localparam int DMIN = 50;
    localparam int DMAX = 100;
    localparam int DCTR = 75;
    localparam int STEP = 10;
    localparam int STG  = 4;
    localparam int F     = PER + GRD;
    localparam int ARM_N = SF * F + 1;
    localparam int RUN_N = (SF + 1) * F;
`ifdef SERVO_STAGGER_EN
    localparam int LAST_CH_OFS = 1 + (NCH - 1) * STG;
`else
    localparam int LAST_CH_OFS = 1;
`endif

    logic                 clk;
    logic                 reset;
    logic                 run;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [2:0]           cmd_ch;
    logic [DBIT-1:0]      cmd_duty;
    logic                 big_tick;
    logic [NCH-1:0]       pwm_en;
    logic [NCH*DBIT-1:0]  duty_out;
    logic                 frame_tick;
    logic                 cmd_err;
    logic [1:0]           state_dbg;

    servo_frame_scheduler #(
        .NCH(NCH), .DBIT(DBIT), .PERIOD(PER), .GUARD(GRD), .SETTLE_FRAMES(SF),
        .DUTY_MIN(DMIN), .DUTY_MAX(DMAX), .DUTY_CTR(DCTR), .SLEW_STEP(STEP),
        .STAGGER_CYC(STG)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_ch(cmd_ch), .cmd_duty(cmd_duty),
        .big_tick(big_tick), .pwm_en(pwm_en), .duty_out(duty_out),
        .frame_tick(frame_tick), .cmd_err(cmd_err), .state_dbg(state_dbg)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Scoreboard state
    int checks = 0;
    int errors = 0;
    int n;
    int tgt [NCH];
    int cur [NCH];
    bit frame_on;
    bit exp_err;
    int big_seen;
    int pwm_bits;
    int first_pwm_n;
    int last_ch_n;

    typedef struct {
        int ch;
        int duty;
        bit err;
    } cmd_vec_t;

    cmd_vec_t tbl [8];
    int fin_exp [NCH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, n);
        end
    endtask

    function automatic int duty_of(input int k);
        return int'(duty_out[k*DBIT +: DBIT]);
    endfunction

    function automatic bit ready_at(input int m);
        return (m >= ARM_N) && (m % F != 0);
    endfunction

    function automatic int clampv(input int d);
        if (d < DMIN) return DMIN;
        if (d > DMAX) return DMAX;
        return d;
    endfunction

    task automatic model_reset();
        n = 0;
        for (int k = 0; k < NCH; k++) begin
            tgt[k] = DCTR;
            cur[k] = DCTR;
        end
        frame_on    = 1'b0;
        exp_err     = 1'b0;
        big_seen    = 0;
        pwm_bits    = 0;
        first_pwm_n = -1;
        last_ch_n   = -1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_big_tick"},   32'(big_tick),   0);
        check({tag, "_pwm_en"},     32'(pwm_en),     0);
        check({tag, "_frame_tick"}, 32'(frame_tick), 0);
        check({tag, "_cmd_err"},    32'(cmd_err),    0);
        check({tag, "_cmd_ready"},  32'(cmd_ready),  0);
        for (int k = 0; k < NCH; k++) check({tag, "_duty"}, 32'(duty_of(k)), DCTR);
    endtask

    // One clock: advance the model across the edge, then compare at negedge.
    task automatic cycle(output bit acc);
        int pos;
        bit run_pre;
        int ch_pre;
        int d_pre;
        logic [NCH-1:0] exp_pwm;
        acc     = cmd_valid && ready_at(n);
        run_pre = run;
        ch_pre  = int'(cmd_ch);
        d_pre   = int'(cmd_duty);
        @(posedge clk);
        n++;
        pos = n % F;
        if (pos == 0 && n >= RUN_N) begin
            for (int k = 0; k < NCH; k++) begin
                if (tgt[k] > cur[k])      cur[k] = (tgt[k] - cur[k] > STEP) ? cur[k] + STEP : tgt[k];
                else if (tgt[k] < cur[k]) cur[k] = (cur[k] - tgt[k] > STEP) ? cur[k] - STEP : tgt[k];
            end
        end
        exp_err = acc && (ch_pre >= NCH);
        if (acc && ch_pre < NCH) tgt[ch_pre] = clampv(d_pre);
        if (pos == 1) frame_on = (n - 1 >= RUN_N) && run_pre;
        exp_pwm = '0;
        for (int k = 0; k < NCH; k++) begin
`ifdef SERVO_STAGGER_EN
            if (frame_on && pos == 1 + k * STG) exp_pwm[k] = 1'b1;
`else
            if (frame_on && pos == 1) exp_pwm[k] = 1'b1;
`endif
        end
        @(negedge clk);
        check("frame_tick", 32'(frame_tick), 32'(pos == 0));
        check("big_tick",   32'(big_tick),   32'(n == ARM_N));
        check("cmd_ready",  32'(cmd_ready),  32'(ready_at(n)));
        check("cmd_err",    32'(cmd_err),    32'(exp_err));
        check("pwm_en",     32'(pwm_en),     32'(exp_pwm));
        for (int k = 0; k < NCH; k++) check("duty_out", 32'(duty_of(k)), 32'(cur[k]));
        big_seen += int'(big_tick);
        pwm_bits += $countones(pwm_en);
        if (pwm_en != '0 && first_pwm_n < 0) first_pwm_n = n;
        if (pwm_en[NCH-1] && last_ch_n < 0)  last_ch_n = n;
    endtask

    task automatic run_until(input int target_n);
        bit a;
        while (n < target_n) cycle(a);
    endtask

    task automatic wait_pos(input int p);
        bit a;
        do cycle(a); while (n % F != p);
    endtask

    task automatic do_write(input int ch, input int duty, output int acc_n);
        bit a;
        int budget;
        budget    = 0;
        acc_n     = -1;
        cmd_ch    = 3'(ch);
        cmd_duty  = DBIT'(duty);
        cmd_valid = 1'b1;
        while (acc_n < 0 && budget < 1000) begin
            int pre;
            pre = n;
            cycle(a);
            budget++;
            if (a) acc_n = pre;
        end
        cmd_valid = 1'b0;
        if (acc_n < 0) check("write_timeout", 0, 1);
    endtask

    initial begin
        int acc_n;
        int pb0;
        int f0;
        bit a;

        tbl[0] = '{ch: 0, duty: 10,  err: 1'b0};
        tbl[1] = '{ch: 1, duty: 500, err: 1'b0};
        tbl[2] = '{ch: 6, duty: 90,  err: 1'b1};
        tbl[3] = '{ch: 3, duty: 60,  err: 1'b0};
        tbl[4] = '{ch: 3, duty: 99,  err: 1'b0};
        tbl[5] = '{ch: 7, duty: 55,  err: 1'b1};
        tbl[6] = '{ch: 4, duty: 75,  err: 1'b0};
        tbl[7] = '{ch: 2, duty: 100, err: 1'b0};
        fin_exp = '{50, 100, 100, 99, 75};

        // Reset
        reset = 1'b0; run = 1'b0; cmd_valid = 1'b0; cmd_ch = '0; cmd_duty = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b1;
        run   = 1'b1;

        // Write held pending through settling, then ch2 slews 85, 95, 100
        do_write(2, 100, acc_n);
        check("pend_accept_edge", 32'(acc_n), ARM_N);
        run_until(RUN_N);
        check("slew_ch2_f1", 32'(duty_of(2)), 85);
        check("slew_ch0_f1", 32'(duty_of(0)), 75);
        run_until(RUN_N + F);
        check("slew_ch2_f2", 32'(duty_of(2)), 95);
        run_until(RUN_N + 2 * F);
        check("slew_ch2_f3", 32'(duty_of(2)), 100);
        check("slew_ch4_f3", 32'(duty_of(4)), 75);
        check("big_tick_count", 32'(big_seen), 1);
        check("first_pwm_edge", 32'(first_pwm_n), RUN_N + 1);

        // Table of writes: clamping, bad channels, last write wins
        for (int i = 0; i < 8; i++) begin
            do_write(tbl[i].ch, tbl[i].duty, acc_n);
            check("tbl_cmd_err", 32'(cmd_err), 32'(tbl[i].err));
            repeat ($urandom_range(1, 40)) cycle(a);
        end
        run_until(n + 6 * F);
        for (int k = 0; k < NCH; k++) check("tbl_final_duty", 32'(duty_of(k)), 32'(fin_exp[k]));

        // cmd_valid held across the update cycle
        wait_pos(F - 1);
        check("rdy_before_update", 32'(cmd_ready), 1);
        cycle(a);
        check("rdy_in_update", 32'(cmd_ready), 0);
        do_write(4, 95, acc_n);
        check("update_accept_pos", 32'(acc_n % F), 1);
        run_until((acc_n / F + 1) * F);
        check("update_applied_ch4", 32'(duty_of(4)), 85);

        // run low mid-frame for two frame boundaries, then high again
        wait_pos(100);
        run = 1'b0;
        pb0 = pwm_bits;
        f0  = n / F;
        run_until((f0 + 2) * F + 100);
        run = 1'b1;
        run_until((f0 + 3) * F);
        check("hold_no_pwm", 32'(pwm_bits - pb0), 0);
        run_until((f0 + 4) * F);
        check("resume_pwm_bits", 32'(pwm_bits - pb0), NCH);

        // Randomized writes and run toggles against the model
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(1, 30)) cycle(a);
            if ($urandom_range(0, 9) < 7) do_write($urandom_range(0, 7), $urandom_range(0, 200), acc_n);
            else run = ~run;
        end
        run = 1'b1;
        run_until(n + 2 * F);

        // Asynchronous reset mid-frame, then the full sequence again
        wait_pos(77);
        #2 reset = 1'b0;
        #1 check_reset_vals("async_rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        run_until(RUN_N + F + 30);
        check("rearm_big_count", 32'(big_seen), 1);
        check("rearm_first_pwm", 32'(first_pwm_n), RUN_N + 1);
        check("last_ch_pwm_edge", 32'(last_ch_n), RUN_N + LAST_CH_OFS);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
